// File: rtl/axilite_mem_backend.sv
// Word-addressed register memory behind the AXI-lite slave: independent write and read
// engines with programmable ack latency, byte strobes and out-of-range error flags.
module axilite_mem_backend #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 64,
  parameter logic [ADDR_W-1:0] MEM_ADDR_START = 'h10000000,
  parameter int                MEM_ADDR_RANGE = 5,
  parameter int                W_LATENCY      = 1,
  parameter int                R_LATENCY      = 2
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                mem_w_req,
  input  logic [ADDR_W-1:0]   mem_w_addr,
  input  logic [DATA_W-1:0]   mem_w_data,
  input  logic [DATA_W/8-1:0] mem_w_strb,
  output logic                mem_w_ack,
  output logic                mem_w_err,
  input  logic                mem_r_req,
  input  logic [ADDR_W-1:0]   mem_r_addr,
  output logic                mem_r_ack,
  output logic [DATA_W-1:0]   mem_r_data,
  output logic                mem_r_err
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_ADDR_RANGE > 1) ? $clog2(MEM_ADDR_RANGE) : 1;
  localparam logic [3:0] W_CNT_INIT = 4'(W_LATENCY - 1);
  localparam logic [3:0] R_CNT_INIT = 4'(R_LATENCY - 1);

  if (W_LATENCY < 1 || W_LATENCY > 15) begin : g_bad_w_latency
    $error("W_LATENCY must be within 1..15");
  end
  if (R_LATENCY < 1 || R_LATENCY > 15) begin : g_bad_r_latency
    $error("R_LATENCY must be within 1..15");
  end
  if (DATA_W % 8 != 0 || MEM_ADDR_RANGE < 1) begin : g_bad_geometry
    $error("DATA_W must be a multiple of 8 and MEM_ADDR_RANGE >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  // Offset is taken modulo 2^ADDR_W, so addresses below the base wrap high and fail the idx test too.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - MEM_ADDR_START;
    return (addr >= MEM_ADDR_START) && ((off >> OFF_W) < ADDR_W'(MEM_ADDR_RANGE));
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - MEM_ADDR_START) >> OFF_W);
  endfunction

  logic [DATA_W-1:0] r_mem [MEM_ADDR_RANGE];

  // ---------------- write engine ----------------
  state_t              r_w_state, w_w_state_next;
  logic [3:0]          r_w_cnt;
  logic [ADDR_W-1:0]   r_w_addr, w_w_addr;
  logic [DATA_W-1:0]   r_w_data, w_w_data;
  logic [STRB_W-1:0]   r_w_strb, w_w_strb;
  logic                r_w_ack, r_w_err, w_w_go, w_w_inr;
  logic [IDX_W-1:0]    w_w_idx;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_w_state <= S_IDLE;
      r_w_cnt   <= '0;
      r_w_addr  <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_w_ack   <= 1'b0;
      r_w_err   <= 1'b0;
    end else begin
      r_w_state <= w_w_state_next;
      if (r_w_state == S_IDLE && mem_w_req) begin
        r_w_cnt  <= W_CNT_INIT;
        r_w_addr <= mem_w_addr;
        r_w_data <= mem_w_data;
        r_w_strb <= mem_w_strb;
      end else if (r_w_state == S_WAIT) begin
        r_w_cnt <= r_w_cnt - 4'd1;
      end
      r_w_ack <= (w_w_state_next == S_ACK);
      if (w_w_go)                           r_w_err <= !w_w_inr;
      else if (w_w_state_next == S_IDLE)    r_w_err <= 1'b0;
    end
  end

  always_comb begin
    w_w_state_next = r_w_state;
    case (r_w_state)
      S_IDLE:  if (mem_w_req) w_w_state_next = (W_LATENCY == 1) ? S_ACK : S_WAIT;
      S_WAIT:  if (r_w_cnt == 4'd1) w_w_state_next = S_ACK;
      S_ACK:   if (!mem_w_req) w_w_state_next = S_IDLE;
      default: w_w_state_next = S_IDLE;
    endcase
  end

  // With unit latency the commit happens on the sample edge, so use the live inputs there.
  always_comb begin
    w_w_go   = (r_w_state == S_IDLE && mem_w_req && W_LATENCY == 1) ||
               (r_w_state == S_WAIT && r_w_cnt == 4'd1);
    w_w_addr = (r_w_state == S_IDLE) ? mem_w_addr : r_w_addr;
    w_w_data = (r_w_state == S_IDLE) ? mem_w_data : r_w_data;
    w_w_strb = (r_w_state == S_IDLE) ? mem_w_strb : r_w_strb;
    w_w_inr  = f_in_range(w_w_addr);
    w_w_idx  = f_idx(w_w_addr);
  end

  // ---------------- read engine ----------------
  state_t              r_r_state, w_r_state_next;
  logic [3:0]          r_r_cnt;
  logic [ADDR_W-1:0]   r_r_addr, w_r_addr;
  logic [DATA_W-1:0]   r_r_data;
  logic                r_r_ack, r_r_err, w_r_go, w_r_inr;
  logic [IDX_W-1:0]    w_r_idx;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_r_state <= S_IDLE;
      r_r_cnt   <= '0;
      r_r_addr  <= '0;
      r_r_data  <= '0;
      r_r_ack   <= 1'b0;
      r_r_err   <= 1'b0;
    end else begin
      r_r_state <= w_r_state_next;
      if (r_r_state == S_IDLE && mem_r_req) begin
        r_r_cnt  <= R_CNT_INIT;
        r_r_addr <= mem_r_addr;
      end else if (r_r_state == S_WAIT) begin
        r_r_cnt <= r_r_cnt - 4'd1;
      end
      r_r_ack <= (w_r_state_next == S_ACK);
      if (w_r_go) begin
        r_r_err  <= !w_r_inr;
        r_r_data <= w_r_inr ? r_mem[w_r_idx] : '0;
      end else if (w_r_state_next == S_IDLE) begin
        r_r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_r_state_next = r_r_state;
    case (r_r_state)
      S_IDLE:  if (mem_r_req) w_r_state_next = (R_LATENCY == 1) ? S_ACK : S_WAIT;
      S_WAIT:  if (r_r_cnt == 4'd1) w_r_state_next = S_ACK;
      S_ACK:   if (!mem_r_req) w_r_state_next = S_IDLE;
      default: w_r_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_r_go   = (r_r_state == S_IDLE && mem_r_req && R_LATENCY == 1) ||
               (r_r_state == S_WAIT && r_r_cnt == 4'd1);
    w_r_addr = (r_r_state == S_IDLE) ? mem_r_addr : r_r_addr;
    w_r_inr  = f_in_range(w_r_addr);
    w_r_idx  = f_idx(w_r_addr);
  end

  // ---------------- storage: read capture above sees the pre-commit value ----------------
  for (genvar gi = 0; gi < MEM_ADDR_RANGE; gi++) begin : g_word
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_mem[gi] <= '0;
      end else if (w_w_go && w_w_inr && w_w_idx == IDX_W'(gi)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_w_strb[b]) r_mem[gi][8*b +: 8] <= w_w_data[8*b +: 8];
        end
      end
    end
  end

  assign mem_w_ack  = r_w_ack;
  assign mem_w_err  = r_w_err;
  assign mem_r_ack  = r_r_ack;
  assign mem_r_err  = r_r_err;
  assign mem_r_data = r_r_data;

endmodule

// File: doc/axilite_mem_backend.md
Name: axilite_mem_backend

Overview:
- Word-addressed register memory that sits directly downstream of the AXI-lite slave and serves its mem_w_req/mem_r_req handshakes.
- Independent write and read engines share one array of MEM_ADDR_RANGE words of DATA_W bits each.
- Byte-strobe writes, programmable ack latency per direction, out-of-range error flags.
- Read and write may be in flight concurrently.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; multiple of 8
MEM_ADDR_START, 'h10000000, byte address of word 0
MEM_ADDR_RANGE, 5, number of words (>=1)
W_LATENCY, 1, edges from write-req sample to ack rise (>=1, <=15)
R_LATENCY, 2, edges from read-req sample to ack rise (>=1, <=15)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
mem_w_req  in  1  write request level, held until ack seen and accepted upstream
mem_w_addr  in  ADDR_W  write byte address
mem_w_data  in  DATA_W  write data
mem_w_strb  in  DATA_W/8  byte enables, bit i -> data[8i+7:8i]
mem_w_ack  out  1  write done; level, held while mem_w_req high
mem_w_err  out  1  write was out of range; valid while mem_w_ack high
mem_r_req  in  1  read request level
mem_r_addr  in  ADDR_W  read byte address
mem_r_ack  out  1  read data valid; level, held while mem_r_req high
mem_r_data  out  DATA_W  read data, stable while mem_r_ack high
mem_r_err  out  1  read was out of range; valid while mem_r_ack high

Behaviour:
- Reset (async assert, sync deassert): both FSMs go to IDLE. mem_w_ack, mem_r_ack, mem_w_err and mem_r_err reset to 0. mem_r_data resets to 0. All memory words reset to 0. An in-flight op is abandoned with no partial write.
- Decode:
  - off = addr - MEM_ADDR_START, computed unsigned at ADDR_W bits.
  - idx = off >> log2(DATA_W/8); the low byte-offset bits are ignored, so unaligned addresses truncate.
  - In range iff addr >= MEM_ADDR_START and idx < MEM_ADDR_RANGE.
- Per-engine FSM (W and R identical; LAT = W_LATENCY or R_LATENCY):
  - IDLE: req sampled high at edge E0. Latch addr (and data/strb for writes), load cnt = LAT-1. Go to ACK if LAT==1, else WAIT.
  - WAIT: decrement cnt each edge; at the edge where cnt==1, go to ACK. The req level is ignored in WAIT.
  - Ack rises at edge E0+LAT-1 and is registered.
  - At the ack-rise edge:
    - Write engine: commits the latched data to word idx, only the bytes whose strb bit is set. Out-of-range writes are dropped and set mem_w_err.
    - Read engine: captures word idx into mem_r_data. Out-of-range reads return 0 and set mem_r_err.
  - ACK: ack and err held. When req is sampled low, go to IDLE; ack and err clear at that edge.
  - The next request can be sampled in the cycle after that edge; there are no back-to-back acks without an ack-low cycle.
- mem_r_data holds its last value after ack falls, until the next capture.
- Inputs are sampled only at E0; later changes to addr/data/strb during WAIT/ACK have no effect.
- Simultaneous same-word write-commit and read-capture on the same edge: the read returns the pre-write value (read-before-write).
- mem_w_strb == 0 on an in-range write: normal ack, no memory change, err=0.
- Each engine's cnt is 4 bits; LAT outside 1..15 is illegal (elaboration assertion).
- Implementation: two FSMs, two counters, address decode, MEM_ADDR_RANGE x DATA_W flop array with byte enables; no multicycle paths.

Test Plan:
1. Reset, then write 0x10000008 data 0x1122334455667788 strb 0xFF, W_LATENCY=1 -> mem_w_ack high in the cycle after E0, err=0. Drop req -> ack low next edge. Read 0x10000008 with R_LATENCY=2 -> ack after E0+1, mem_r_data 0x1122334455667788.
2. Write 0x10000008 data 0xAAAAAAAAAAAAAAAA strb 0x0F, then read it back -> 0x11223344AAAAAAAA. Repeat with strb 0x00 -> data unchanged, ack given.
3. Read 0x10000028 (idx 5) and 0x0FFFFFF8 -> mem_r_ack with mem_r_err=1 and data 0. Write 0x10000028 -> mem_w_err=1; read back of idx 0..4 is unchanged.
4. Hold mem_r_req high for 10 cycles after ack -> ack, data and err stay stable throughout. Then drop req and immediately re-raise it for 0x10000020 -> one ack-low cycle, then a new ack with word 4 contents.
5. Write idx 2 with W_LATENCY=2 and read idx 2 with R_LATENCY=2, both req raised on the same edge, old word 0, new data 0x5A5A5A5A5A5A5A5A -> read returns 0. A subsequent read returns 0x5A5A5A5A5A5A5A5A.
6. Assert aresetn low while the write FSM is in WAIT (W_LATENCY=4) -> acks drop immediately and the target word stays 0. After release, a read of that word returns 0.
